uart_rx_sampler: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx_sampler.sv | 151 +++++++++++++++
 tb/tb_uart_rx_sampler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, baud divisors and frame width.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

  localparam int unsigned BPS115200 = 868;
  localparam int unsigned BPS230400 = 434;
  localparam int unsigned BPS460800 = 217;
  localparam int unsigned BPSTEST   = 5;

  localparam int unsigned DATA_BITS = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer; both stages reset to 1 so an idle-high line reads idle.
module uart_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= d_in;
      r_sync <= r_meta;
    end
  end

  assign q_out = r_sync;

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: mid-bit 3-sample majority vote, glitch-rejecting start detect,
// framing/overrun flags and a one-entry valid/ready holding register.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = BPS115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  rx_state_e            r_state;
  rx_state_e            w_state_next;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [1:0]           r_samp;
  logic [DATA_BITS-1:0] r_shreg;
  logic [1:0]           r_prime;
  logic                 r_armed;
  logic                 r_deliver;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic [7:0]           r_data;
  logic                 r_valid;

  logic w_rx_s;
  logic w_at_lo;
  logic w_at_mid;
  logic w_at_decide;
  logic w_at_wrap;
  logic w_vote;
  logic w_start_det;
  logic w_last_bit;
  logic w_stop_ok;
  logic w_stop_bad;
  logic w_shift_en;
  logic w_load;

  uart_sync2 #(
    .WIDTH(1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_in (rx_in),
    .q_out(w_rx_s)
  );

  assign w_at_lo     = (r_clk_cnt == CNT_W'(HALF - 1));
  assign w_at_mid    = (r_clk_cnt == CNT_W'(HALF));
  assign w_at_decide = (r_clk_cnt == CNT_W'(HALF + 1));
  assign w_at_wrap   = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_vote      = maj3(r_samp[0], r_samp[1], w_rx_s);
  assign w_start_det = r_armed && !w_rx_s;
  assign w_last_bit  = (r_bit_idx == IDX_W'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (w_start_det) w_state_next = StStart;
      StStart: begin
        if (w_at_decide && w_vote) w_state_next = StIdle;
        else if (w_at_wrap)        w_state_next = StData;
      end
      StData:     if (w_at_wrap && w_last_bit) w_state_next = StStop;
      StStop:     if (w_at_decide) w_state_next = w_vote ? StIdle : StWaitHigh;
      StWaitHigh: if (w_rx_s) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy       = (r_state != StIdle);
    w_shift_en = (r_state == StData) && w_at_decide;
    w_stop_ok  = (r_state == StStop) && w_at_decide && w_vote;
    w_stop_bad = (r_state == StStop) && w_at_decide && !w_vote;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_samp    <= '0;
      r_shreg   <= '0;
    end else begin
      // The detect cycle itself is sample 0 of the start bit.
      if (r_state == StIdle)  r_clk_cnt <= w_start_det ? CNT_W'(1) : '0;
      else if (w_at_wrap)     r_clk_cnt <= '0;
      else                    r_clk_cnt <= r_clk_cnt + CNT_W'(1);

      if (r_state != StData)  r_bit_idx <= '0;
      else if (w_at_wrap)     r_bit_idx <= r_bit_idx + IDX_W'(1);

      if (w_at_lo)  r_samp[0] <= w_rx_s;
      if (w_at_mid) r_samp[1] <= w_rx_s;
      if (w_shift_en) r_shreg <= {w_vote, r_shreg[DATA_BITS-1:1]};
    end
  end

  // The synchronizer's reset value of 1 is not a real line sample, so arming
  // waits until both stages have been loaded from rx_in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prime <= '0;
      r_armed <= 1'b0;
    end else begin
      r_prime <= {r_prime[0], 1'b1};
      if (r_prime[1] && w_rx_s) r_armed <= 1'b1;
    end
  end

  assign w_load = r_deliver && (!r_valid || rx_data_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_deliver   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_deliver   <= w_stop_ok;
      r_frame_err <= w_stop_bad;
      r_overrun   <= r_deliver && !w_load;
      if (w_load) r_data <= r_shreg;
      if (w_load)             r_valid <= 1'b1;
      else if (rx_data_ready) r_valid <= 1'b0;
    end
  end

  assign rx_data       = r_data;
  assign rx_data_valid = r_valid;
  assign frame_err     = r_frame_err;
  assign overrun_err   = r_overrun;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler at 16 clocks per bit.
module tb_uart_rx_sampler;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 9 * CPB + HALF + 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx_in = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  uart_rx_sampler #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_data_ready(ready),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = 8'h00;
  int n_rise = 0, n_vcyc = 0, n_ferr = 0, n_ovr = 0, n_busy = 0, n_unst = 0;
  int last_rise = 0;
  logic [7:0] last_data = 8'h00;
  int rise_q[$];
  logic [7:0] rdata_q[$];

  always @(negedge clk) begin
    prev_v <= rx_data_valid;
    prev_d <= rx_data;
    if (rx_data_valid && !prev_v) begin
      n_rise    <= n_rise + 1;
      last_rise <= cyc;
      last_data <= rx_data;
      rise_q.push_back(cyc);
      rdata_q.push_back(rx_data);
    end
    if (rx_data_valid) n_vcyc <= n_vcyc + 1;
    if (frame_err)     n_ferr <= n_ferr + 1;
    if (overrun_err)   n_ovr  <= n_ovr + 1;
    if (busy)          n_busy <= n_busy + 1;
    if (rx_data_valid && prev_v && rx_data != prev_d) n_unst <= n_unst + 1;
  end

  int checks = 0;
  int errors = 0;
  int s_rise, s_vcyc, s_ferr, s_ovr, s_busy, s_unst;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic snap();
    s_rise = n_rise; s_vcyc = n_vcyc; s_ferr = n_ferr;
    s_ovr  = n_ovr;  s_busy = n_busy; s_unst = n_unst;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Ideal-timing 8N1 frame; optional one-cycle inverted spike at mid-bit of each data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit spike,
                            output int e0);
    rx_in = 1'b0;
    e0 = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < CPB; k++) begin
        rx_in = (spike && k == HALF) ? ~b[i] : b[i];
        @(negedge clk);
      end
    end
    rx_in = stop;
    repeat (CPB) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    bit         spike;
    int         hold_low;
    int         exp_rise;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    int base;
    int exp_t[$];
    logic [7:0] exp_b[$];
    logic [7:0] rb;
    bit sp;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 0,   1, 8'hA5, 0};
    vecs[1] = '{8'h0F, 1'b1, 1'b1, 0,   1, 8'h0F, 0};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 100, 0, 8'h00, 1};
    vecs[3] = '{8'h12, 1'b1, 1'b0, 0,   1, 8'h12, 0};
    vecs[4] = '{8'hC6, 1'b1, 1'b1, 0,   1, 8'hC6, 0};

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset rx_data", int'(rx_data), 0);
    chk("reset valid", int'(rx_data_valid), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset overrun_err", int'(overrun_err), 0);
    chk("reset busy", int'(busy), 0);
    reset = 1'b1;
    idle(10);

    for (int i = 0; i < 5; i++) begin
      snap();
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].spike, e0);
      if (vecs[i].hold_low > 0) begin
        rx_in = 1'b0;
        repeat (vecs[i].hold_low) @(negedge clk);
      end
      idle(2 * CPB);
      chk($sformatf("vec%0d rise", i), n_rise - s_rise, vecs[i].exp_rise);
      if (vecs[i].exp_rise == 1) begin
        chk($sformatf("vec%0d data", i), int'(last_data), int'(vecs[i].exp_data));
        chk($sformatf("vec%0d latency", i), last_rise - e0, LAT);
        chk($sformatf("vec%0d valid cycles", i), n_vcyc - s_vcyc, 1);
      end
      chk($sformatf("vec%0d frame_err", i), n_ferr - s_ferr, vecs[i].exp_ferr);
      chk($sformatf("vec%0d overrun", i), n_ovr - s_ovr, 0);
    end

    // Start-bit glitch.
    snap();
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * CPB);
    chk("glitch busy cycles", n_busy - s_busy, HALF + 1);
    chk("glitch rise", n_rise - s_rise, 0);
    chk("glitch errors", (n_ferr - s_ferr) + (n_ovr - s_ovr), 0);
    send_frame(8'h55, 1'b1, 1'b0, e0);
    idle(2 * CPB);
    chk("post-glitch rise", n_rise - s_rise, 1);
    chk("post-glitch data", int'(last_data), 'h55);

    // Back-to-back with consumer stalled.
    ready = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1, 1'b0, e0);
    send_frame(8'h81, 1'b1, 1'b0, e0);
    idle(2 * CPB);
    chk("overrun rise", n_rise - s_rise, 1);
    chk("overrun held data", int'(rx_data), 'h3C);
    chk("overrun valid", int'(rx_data_valid), 1);
    chk("overrun pulses", n_ovr - s_ovr, 1);
    chk("overrun frame_err", n_ferr - s_ferr, 0);
    chk("overrun data stable", n_unst - s_unst, 0);
    ready = 1'b1;
    @(negedge clk);
    chk("handshake clears valid", int'(rx_data_valid), 0);

    // Line held low through reset release.
    reset = 1'b0;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    snap();
    repeat (40) @(negedge clk);
    chk("low-at-reset busy", n_busy - s_busy, 0);
    chk("low-at-reset rise", n_rise - s_rise, 0);
    idle(2 * CPB);
    ready = 1'b0;
    send_frame(8'h7E, 1'b1, 1'b0, e0);
    idle(2 * CPB);
    chk("low-at-reset frame rise", n_rise - s_rise, 1);
    chk("low-at-reset frame data", int'(rx_data), 'h7E);
    chk("low-at-reset frame valid", int'(rx_data_valid), 1);

    // Reset during data bit 4 with a byte still held.
    fork
      send_frame(8'hC3, 1'b1, 1'b0, e0);
      begin
        repeat (5 * CPB + HALF) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset rx_data", int'(rx_data), 0);
        chk("midreset valid", int'(rx_data_valid), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset errors", int'(frame_err) + int'(overrun_err), 0);
      end
    join
    idle(4);
    reset = 1'b1;
    ready = 1'b1;
    idle(10);
    snap();
    send_frame(8'h5A, 1'b1, 1'b0, e0);
    idle(2 * CPB);
    chk("post-reset rise", n_rise - s_rise, 1);
    chk("post-reset data", int'(last_data), 'h5A);
    chk("post-reset latency", last_rise - e0, LAT);

    // Random frames, gaps and spikes against expected byte/arrival-time model.
    base = rise_q.size();
    for (int j = 0; j < 12; j++) begin
      rb = 8'($urandom);
      sp = 1'($urandom_range(0, 1));
      idle($urandom_range(0, 12));
      send_frame(rb, 1'b1, sp, e0);
      exp_b.push_back(rb);
      exp_t.push_back(e0 + LAT);
    end
    idle(2 * CPB);
    chk("random count", rise_q.size() - base, exp_b.size());
    for (int j = 0; j < exp_b.size(); j++) begin
      if (base + j < rise_q.size()) begin
        chk($sformatf("random%0d data", j), int'(rdata_q[base + j]), int'(exp_b[j]));
        chk($sformatf("random%0d time", j), rise_q[base + j], exp_t[j]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
